// File: rtl/msu_result_capture.sv
// msu_result_capture: takes in the squaring unit's result stream (t_current, then
// sq_out, least-significant word first) and rebuilds it as one parallel frame.
// The frame is handed to the host through a valid/ready handshake. While a
// captured frame is still waiting to be taken, the block stalls the stream.
// Optional feature: define MSU_RESULT_TIMEOUT_EN to build a stall watchdog on COLLECT.
module msu_result_capture #(
  parameter int AXI_LEN        = 32,
  parameter int T_LEN          = 64,
  parameter int SQ_OUT_BITS    = 1024,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_xfer,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [AXI_LEN-1:0]     s_axis_tdata,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [T_LEN-1:0]       result_t,
  output logic [SQ_OUT_BITS-1:0] result_sq,
  output logic                   frame_err,
  output logic                   timeout
);

  localparam int FRAME_WORDS = T_LEN/AXI_LEN + SQ_OUT_BITS/AXI_LEN;
  localparam int FRAME_BITS  = FRAME_WORDS * AXI_LEN;
  localparam int CNT_W       = $clog2(FRAME_WORDS + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

  state_t                  state, state_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic                    pend, pend_n;
  logic                    err_n, to_n;
  logic                    frame_err_r, timeout_r;
  logic [FRAME_BITS-1:0]   frame;
  logic                    hs;
  logic                    stall_hit;

  // The handshake signals are decoded from registered state only, so the stream side does not see combinational paths from its own inputs.
  assign s_axis_tready = (state == COLLECT);
  assign result_valid  = (state == HOLD);
  assign hs            = s_axis_tvalid && s_axis_tready;
  assign result_t      = frame[T_LEN-1:0];
  assign result_sq     = frame[FRAME_BITS-1:T_LEN];
  assign frame_err     = frame_err_r;
  assign timeout       = timeout_r;

`ifdef MSU_RESULT_TIMEOUT_EN
  localparam int STALL_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [STALL_W-1:0] stall;

  assign stall_hit = (stall == STALL_W'(TIMEOUT_CYCLES - 1));

  // Stall watchdog: counts COLLECT cycles since the last accepted word or the last frame (re)start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall <= '0;
    else if (state != COLLECT || hs || start_xfer)
      stall <= '0;
    else
      stall <= stall + STALL_W'(1);
  end
`else
  assign stall_hit = 1'b0;
`endif

  // Next-state logic. In COLLECT, start_xfer has priority over a word that arrives in the same cycle; that word becomes word 0 of the new frame.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pend_n  = pend;
    err_n   = 1'b0;
    to_n    = 1'b0;
    case (state)
      IDLE: begin
        if (start_xfer) begin
          state_n = COLLECT;
          cnt_n   = '0;
        end
      end
      COLLECT: begin
        if (start_xfer) begin
          err_n = (cnt != '0);
          cnt_n = hs ? CNT_W'(1) : '0;
        end else if (hs) begin
          if (cnt == CNT_W'(FRAME_WORDS - 1)) begin
            state_n = HOLD;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end else if (stall_hit) begin
          state_n = IDLE;
          cnt_n   = '0;
          to_n    = 1'b1;
        end
      end
      HOLD: begin
        if (start_xfer) pend_n = 1'b1;
        if (result_ready) begin
          // A start seen during HOLD, including in the accept cycle itself, goes directly to COLLECT.
          state_n = (pend || start_xfer) ? COLLECT : IDLE;
          pend_n  = 1'b0;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        pend_n  = 1'b0;
      end
    endcase
  end

  // Control registers and the single-cycle error pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      pend        <= 1'b0;
      frame_err_r <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      pend        <= pend_n;
      frame_err_r <= err_n;
      timeout_r   <= to_n;
    end
  end

  // Frame shift register: each accepted word enters at the top, so after a full frame word 0 ends up at the bottom.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      frame <= '0;
    else if (hs)
      frame <= {s_axis_tdata, frame[FRAME_BITS-1:AXI_LEN]};
  end

endmodule

// File: doc/msu_result_capture.md
# msu_result_capture

Downstream stage of the modular squaring unit. Consumes the unit's outgoing AXI-stream result frame (t_current followed by sq_out, least-significant word first, no tlast), reassembles it into parallel registers and presents it to the host-control logic through a valid/ready result handshake. It back-pressures the stream while a captured result has not been taken, and detects framing errors.

## Interface
Parameters:
- AXI_LEN, 32: stream word width; divides T_LEN and SQ_OUT_BITS.
- T_LEN, 64: iteration-count width.
- SQ_OUT_BITS, 1024: squarer result width.
- TIMEOUT_CYCLES, 4096: stall limit (used only with MSU_RESULT_TIMEOUT_EN).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start_xfer  in  1  one-cycle pulse announcing a new result frame.
- s_axis_tvalid  in  1  stream word valid.
- s_axis_tready  out  1  stream word accept.
- s_axis_tdata  in  AXI_LEN  stream word.
- result_valid  out  1  captured frame available.
- result_ready  in  1  consumer takes frame.
- result_t  out  T_LEN  captured t_current.
- result_sq  out  SQ_OUT_BITS  captured sq_out.
- frame_err  out  1  one-cycle pulse: partial frame discarded.
- timeout  out  1  one-cycle pulse: frame aborted on stall.

## Operation
- FRAME_WORDS = T_LEN/AXI_LEN + SQ_OUT_BITS/AXI_LEN (34 at defaults). Word k occupies bits [k*AXI_LEN +: AXI_LEN] of {sq, t}; words 0..T_LEN/AXI_LEN-1 form result_t.
- Capture is a right shift register: each accepted word enters at the top, so after FRAME_WORDS words the frame is aligned.
- States IDLE, COLLECT, HOLD.
- IDLE: s_axis_tready=0. start_xfer -> COLLECT, word count cleared.
- COLLECT: s_axis_tready=1. Handshake (tvalid&&tready) shifts word in, increments count (width clog2(FRAME_WORDS+1)). Handshake on word FRAME_WORDS-1 -> HOLD.
- COLLECT with start_xfer and count>0: partial frame discarded, count=0, frame_err pulses, remain COLLECT. If start_xfer and a handshake coincide, start_xfer wins; the word is taken as word 0 of the new frame.
- HOLD: s_axis_tready=0, result_valid=1, result_t/result_sq stable. result_valid&&result_ready -> IDLE, or -> COLLECT if a start_xfer arrived during HOLD (one-deep pending flag; cleared on the transition).
- Words offered in IDLE are not accepted; nothing is lost because tready=0.

## Timing
- Reset (async assert, sync release): state IDLE, count 0, pending 0, s_axis_tready=0, result_valid=0, result_t=0, result_sq=0, frame_err=0, timeout=0.
- s_axis_tready is registered-state decoded: high from the cycle after start_xfer.
- result_valid rises the cycle after the last word handshake; minimum frame latency start_xfer -> result_valid = FRAME_WORDS+1 cycles.
- One word per cycle sustained in COLLECT; no bubble insertion.
- frame_err and timeout are single-cycle, registered, asserted the cycle after the triggering event.
- Reset mid-frame or mid-HOLD discards everything immediately.

## Configuration
- MSU_RESULT_TIMEOUT_EN defined: a stall counter clears on every handshake and on entry to COLLECT, increments each COLLECT cycle without handshake; reaching TIMEOUT_CYCLES-1 returns to IDLE, clears count, pulses timeout. HOLD is never timed out.
- Not defined: no counter is built, timeout tied to 0, COLLECT waits indefinitely.

## Test plan
- Nominal: start_xfer, then 34 back-to-back words 0x1000+k -> result_valid at cycle 35, result_t=0x00001001_00001000, result_sq LSW 0x1002, MSW 0x1021.
- Back-pressure: hold result_ready=0 for 50 cycles with tvalid high -> s_axis_tready=0 throughout, outputs stable; ready=1 -> IDLE next cycle.
- Random tvalid gaps (50% duty) -> same result as nominal, count advances only on handshakes.
- start_xfer after 10 words, then 34 words 0xA000+k -> frame_err one pulse, result_t=0x0000A001_0000A000.
- start_xfer during HOLD -> after accept, state COLLECT directly, next frame captured correctly.
- With MSU_RESULT_TIMEOUT_EN, TIMEOUT_CYCLES=16: 5 words then tvalid=0 -> timeout pulse 16 cycles after last handshake, state IDLE; without macro, no pulse after 1000 cycles.
